// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART definitions: parity encodings, transmitter FSM
//               states and frame-length helper.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_PAR   = 3'd3,
        ST_STOP  = 3'd4
    } tx_state_e;

    function automatic int frame_cycles(input int clk_div, input int data_w,
                                        input int parity, input int stop_bits);
        return clk_div * (1 + data_w + ((parity != PAR_NONE) ? 1 : 0) + stop_bits);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_fifo
// Description : Synchronous FIFO with occupancy count; pop on empty and push
//               on full are ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     txrst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int c_aw = $clog2(DEPTH);
    localparam logic [c_aw:0] c_full_lvl = (c_aw + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [c_aw-1:0]  wptr_q;
    logic [c_aw-1:0]  rptr_q;
    logic [c_aw:0]    level_q;
    logic             w_push;
    logic             w_pop;

    assign full_o    = (level_q == c_full_lvl);
    assign empty_o   = (level_q == '0);
    assign level_o   = level_q;
    assign rd_data_o = mem_q[rptr_q];
    assign w_push    = push_i && !full_o;
    assign w_pop     = pop_i && !empty_o;

    always_ff @(posedge clk or posedge txrst) begin
        if (txrst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            if (w_push) wptr_q <= wptr_q + 1'b1;
            if (w_pop)  rptr_q <= rptr_q + 1'b1;
            if (w_push && !w_pop)      level_q <= level_q + 1'b1;
            else if (!w_push && w_pop) level_q <= level_q - 1'b1;
        end
    end

    // Storage needs no reset: the flushed pointers make old contents unreachable.
    always_ff @(posedge clk) begin
        if (w_push) mem_q[wptr_q] <= wr_data_i;
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_gen.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_gen
// Description : Buffered, parametrised UART transmitter with baud timer,
//               optional parity, 1/2 stop bits and back-to-back framing.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_gen
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = 16,
    parameter int DATA_W     = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          txrst,
    input  logic [DATA_W-1:0]             in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          tx,
    output logic                          busy,
    output logic                          tx_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int c_tmr_w  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int c_bcnt_w = $clog2(DATA_W + 1);
    localparam logic [c_tmr_w-1:0]  c_tmr_last  = c_tmr_w'(CLK_DIV - 1);
    localparam logic [c_bcnt_w-1:0] c_data_last = c_bcnt_w'(DATA_W - 1);
    localparam logic [c_bcnt_w-1:0] c_stop_last = c_bcnt_w'(STOP_BITS - 1);

    tx_state_e            state_q, state_d;
    logic [c_tmr_w-1:0]   timer_q, timer_d;
    logic [c_bcnt_w-1:0]  bcnt_q, bcnt_d;
    logic [DATA_W-1:0]    shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic                 w_pop;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_tmr_end;
    logic [DATA_W-1:0]    w_fifo_data;

    function automatic logic calc_par(input logic [DATA_W-1:0] d);
        return (PARITY == PAR_ODD) ? ~^d : ^d;
    endfunction

    uart_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .txrst     (txrst),
        .push_i    (in_valid),
        .wr_data_i (in_data),
        .pop_i     (w_pop),
        .rd_data_o (w_fifo_data),
        .full_o    (w_full),
        .empty_o   (w_empty),
        .level_o   (fifo_level)
    );

    assign in_ready  = !w_full;
    assign w_tmr_end = (timer_q == c_tmr_last);

    always_ff @(posedge clk or posedge txrst) begin
        if (txrst) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            bcnt_q  <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            bcnt_q  <= bcnt_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q + c_tmr_w'(1);
        bcnt_d  = bcnt_q;
        shift_d = shift_q;
        par_d   = par_q;
        w_pop   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop   = 1'b1;
                    shift_d = w_fifo_data;
                    par_d   = calc_par(w_fifo_data);
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (w_tmr_end) begin
                    bcnt_d  = '0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_tmr_end) begin
                    shift_d = shift_q >> 1;
                    if (bcnt_q == c_data_last) begin
                        bcnt_d  = '0;
                        state_d = (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
                    end else begin
                        bcnt_d = bcnt_q + 1'b1;
                    end
                end
            end
            ST_PAR: begin
                if (w_tmr_end) begin
                    bcnt_d  = '0;
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (w_tmr_end) begin
                    if (bcnt_q == c_stop_last) begin
                        // Chain straight into the next start bit when data is queued.
                        if (!w_empty) begin
                            w_pop   = 1'b1;
                            shift_d = w_fifo_data;
                            par_d   = calc_par(w_fifo_data);
                            state_d = ST_START;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        bcnt_d = bcnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (w_tmr_end || (state_d != state_q) || (state_q == ST_IDLE)) begin
            timer_d = '0;
        end
    end

    // Outputs are registered, so they are decoded from the next-state values.
    always_comb begin
        tx_d = 1'b1;
        unique case (state_d)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shift_d[0];
            ST_PAR:   tx_d = par_d;
            default:  tx_d = 1'b1;
        endcase
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_STOP) && (timer_d == c_tmr_last) && (bcnt_d == c_stop_last);
    end

    assign tx      = tx_q;
    assign busy    = busy_q;
    assign tx_done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_gen
// Description : Directed, table-driven bench for uart_tx_gen across several
//               parameter sets.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] vld;
    logic [7:0] dat;
    logic [4:0] rdy_w, tx_w, busy_w, done_w;
    logic [2:0] lvl_w [5];

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         sel;
        logic [7:0] data;
        int         cdiv;
        int         dw;
        int         par_en;
        logic       pbit;
        int         len;
    } vec_t;

    vec_t vecs[5];

    always #5 clk = ~clk;

    uart_tx_gen u_d0 (.clk(clk), .txrst(rst), .in_data(dat), .in_valid(vld[0]),
        .in_ready(rdy_w[0]), .tx(tx_w[0]), .busy(busy_w[0]), .tx_done(done_w[0]), .fifo_level(lvl_w[0]));
    uart_tx_gen #(.PARITY(1)) u_d1 (.clk(clk), .txrst(rst), .in_data(dat), .in_valid(vld[1]),
        .in_ready(rdy_w[1]), .tx(tx_w[1]), .busy(busy_w[1]), .tx_done(done_w[1]), .fifo_level(lvl_w[1]));
    uart_tx_gen #(.PARITY(2)) u_d2 (.clk(clk), .txrst(rst), .in_data(dat), .in_valid(vld[2]),
        .in_ready(rdy_w[2]), .tx(tx_w[2]), .busy(busy_w[2]), .tx_done(done_w[2]), .fifo_level(lvl_w[2]));
    uart_tx_gen #(.DATA_W(5), .STOP_BITS(2)) u_d3 (.clk(clk), .txrst(rst), .in_data(dat[4:0]),
        .in_valid(vld[3]), .in_ready(rdy_w[3]), .tx(tx_w[3]), .busy(busy_w[3]), .tx_done(done_w[3]),
        .fifo_level(lvl_w[3]));
    uart_tx_gen #(.CLK_DIV(1)) u_d4 (.clk(clk), .txrst(rst), .in_data(dat), .in_valid(vld[4]),
        .in_ready(rdy_w[4]), .tx(tx_w[4]), .busy(busy_w[4]), .tx_done(done_w[4]), .fifo_level(lvl_w[4]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Expected line level at frame cycle i (0-based) for a single frame.
    function automatic logic exp_bit(input vec_t v, input int i);
        int b;
        b = i / v.cdiv;
        if (b == 0) return 1'b0;
        if (b <= v.dw) return v.data[b-1];
        if ((v.par_en != 0) && (b == v.dw + 1)) return v.pbit;
        return 1'b1;
    endfunction

    task automatic run_frame(input vec_t v, input string tag);
        int txe = 0;
        int dne = 0;
        int bse = 0;
        @(negedge clk);
        dat = v.data;
        vld[v.sel] = 1'b1;
        @(posedge clk);
        #1 vld[v.sel] = 1'b0;
        @(negedge clk);
        chk({tag, " level after push"}, 32'(lvl_w[v.sel]), 1);
        for (int i = 0; i < v.len; i++) begin
            @(negedge clk);
            if (tx_w[v.sel] !== exp_bit(v, i)) txe++;
            if (done_w[v.sel] !== (i == v.len - 1)) dne++;
            if (busy_w[v.sel] !== 1'b1) bse++;
        end
        chk({tag, " tx bit errors"}, txe, 0);
        chk({tag, " tx_done errors"}, dne, 0);
        chk({tag, " busy errors"}, bse, 0);
        @(negedge clk);
        chk({tag, " idle tx"}, 32'(tx_w[v.sel]), 1);
        chk({tag, " idle busy"}, 32'(busy_w[v.sel]), 0);
        chk({tag, " idle tx_done"}, 32'(done_w[v.sel]), 0);
    endtask

    initial begin
        logic [7:0] bw [8];
        logic [7:0] rw [4];
        int maxl;
        vec_t bv;

        vecs[0] = '{sel: 0, data: 8'h48, cdiv: 16, dw: 8, par_en: 0, pbit: 1'b0, len: 160};
        vecs[1] = '{sel: 1, data: 8'h07, cdiv: 16, dw: 8, par_en: 1, pbit: 1'b1, len: 176};
        vecs[2] = '{sel: 2, data: 8'h07, cdiv: 16, dw: 8, par_en: 1, pbit: 1'b0, len: 176};
        vecs[3] = '{sel: 3, data: 8'h15, cdiv: 16, dw: 5, par_en: 0, pbit: 1'b0, len: 128};
        vecs[4] = '{sel: 4, data: 8'hFF, cdiv: 1,  dw: 8, par_en: 0, pbit: 1'b0, len: 10};
        bw = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        rw = '{8'hC3, 8'h3C, 8'h5A, 8'h81};

        rst = 1'b1;
        vld = '0;
        dat = '0;
        @(negedge clk);
        @(negedge clk);
        chk("reset tx", 32'(tx_w), 32'h1F);
        chk("reset busy", 32'(busy_w), 0);
        chk("reset tx_done", 32'(done_w), 0);
        chk("reset in_ready", 32'(rdy_w), 32'h1F);
        chk("reset level", 32'(lvl_w[0]), 0);
        rst = 1'b0;

        for (int k = 0; k < 5; k++) begin
            run_frame(vecs[k], $sformatf("vec%0d", k));
        end

        // Burst: in_valid held high with 8 words into the default instance.
        maxl = 0;
        @(negedge clk);
        dat = bw[0];
        vld[0] = 1'b1;
        fork
            begin : drv
                int   idx = 0;
                int   g = 0;
                int   drop = -1;
                logic r;
                logic pend = 1'b0;
                while (idx < 8 && g < 3000) begin
                    r = rdy_w[0];
                    if (pend) chk("in_ready after pop", 32'(r), 1);
                    pend = done_w[0] && !r;
                    if (!r && drop < 0) drop = idx;
                    if (int'(lvl_w[0]) > maxl) maxl = int'(lvl_w[0]);
                    @(posedge clk);
                    if (r) idx++;
                    #1;
                    if (idx < 8) dat = bw[idx];
                    else vld[0] = 1'b0;
                    @(negedge clk);
                    g++;
                end
                chk("burst words accepted", idx, 8);
                chk("burst accepted before drop", drop, 5);
                chk("burst max level", maxl, 4);
            end
            begin : mon
                int g = 0;
                int txe = 0;
                int dne = 0;
                int bse = 0;
                int nd = 0;
                @(negedge clk);
                while (busy_w[0] !== 1'b1 && g < 20) begin
                    @(negedge clk);
                    g++;
                end
                chk("burst busy start", 32'(busy_w[0]), 1);
                bv = vecs[0];
                for (int i = 0; i < 8 * 160; i++) begin
                    if (i > 0) @(negedge clk);
                    bv.data = bw[i / 160];
                    if (tx_w[0] !== exp_bit(bv, i % 160)) txe++;
                    if (done_w[0] !== ((i % 160) == 159)) dne++;
                    if (done_w[0] === 1'b1) nd++;
                    if (busy_w[0] !== 1'b1) bse++;
                end
                chk("burst tx bit errors", txe, 0);
                chk("burst tx_done errors", dne, 0);
                chk("burst tx_done count", nd, 8);
                chk("burst busy drops", bse, 0);
                @(negedge clk);
                chk("burst idle busy", 32'(busy_w[0]), 0);
            end
        join

        // Asynchronous reset in the middle of a data bit with 3 words queued.
        @(negedge clk);
        vld[0] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            dat = rw[k];
            @(posedge clk);
            #1;
        end
        vld[0] = 1'b0;
        repeat (40) @(negedge clk);
        chk("pre-reset level", 32'(lvl_w[0]), 3);
        chk("pre-reset busy", 32'(busy_w[0]), 1);
        #2 rst = 1'b1;
        #1;
        chk("async reset tx", 32'(tx_w[0]), 1);
        chk("async reset busy", 32'(busy_w[0]), 0);
        chk("async reset level", 32'(lvl_w[0]), 0);
        chk("async reset tx_done", 32'(done_w[0]), 0);
        chk("async reset in_ready", 32'(rdy_w[0]), 1);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        begin
            int bad = 0;
            for (int i = 0; i < 200; i++) begin
                @(negedge clk);
                if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0 || done_w[0] !== 1'b0) bad++;
            end
            chk("post-reset quiet cycles", bad, 0);
        end
        bv = vecs[0];
        bv.data = 8'hA5;
        run_frame(bv, "post-reset A5");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
